// File: rtl/dmem_pkg.sv
// Shared constants, types and the load-extension helper for the data memory / LSU.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  // Everything about an accepted request that the response phase still needs.
  typedef struct packed {
    logic       load;
    logic       err;
    logic [2:0] funct3;
    logic [1:0] off;
  } rsp_meta_t;

  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0]  funct3,
                                              input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_BU:   r = {24'h0, b};
      F3_HU:   r = {16'h0, h};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_bram.sv
// DEPTH x 32 synchronous storage: per-byte write enables and a registered read port.
module dmem_bram #(
  parameter int DEPTH = 128,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // NOTE: the array and its read register have no reset so they map onto block RAM;
  // consumers only look at rdata after a read has been issued.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit front end over dmem_bram: request checking, byte lanes, latency FSM
// and load extension behind valid/ready request and response handshakes.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 9,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int AW = $clog2(DEPTH);
  // One extra bit so DEPTH == 2**(ADDR_W-2) still fits as a compare limit.
  localparam logic [ADDR_W-2:0] DEPTH_LIM = (ADDR_W-1)'(DEPTH);
  localparam logic [2:0]        WAIT_INIT = 3'(RD_LAT - 1);

  state_t      state, state_nxt;
  logic [2:0]  cnt, cnt_nxt;
  logic        ready_en;
  rsp_meta_t   meta_q;

  logic        accept;
  logic        f3_ok;
  logic        misaligned;
  logic        out_of_range;
  logic        req_err;
  logic [1:0]  off;
  logic [3:0]  be;
  logic [31:0] wdata_lanes;
  logic [31:0] bram_q;

  assign off          = req_addr[1:0];
  assign out_of_range = {1'b0, req_addr[ADDR_W-1:2]} >= DEPTH_LIM;
  assign req_err      = !f3_ok || misaligned || out_of_range;
  assign accept       = req_valid && req_ready;

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    f3_ok       = 1'b0;
    misaligned  = 1'b0;
    be          = 4'h0;
    wdata_lanes = req_wdata;
    case (req_funct3)
      F3_B: begin
        f3_ok       = 1'b1;
        be          = 4'b0001 << off;
        wdata_lanes = {4{req_wdata[7:0]}};
      end
      F3_H: begin
        f3_ok       = 1'b1;
        misaligned  = off[0];
        be          = 4'b0011 << off;
        wdata_lanes = {2{req_wdata[15:0]}};
      end
      F3_W: begin
        f3_ok      = 1'b1;
        misaligned = (off != 2'b00);
        be         = 4'hf;
      end
      F3_BU: f3_ok = !req_we;
      F3_HU: begin
        f3_ok      = !req_we;
        misaligned = off[0];
      end
      default: f3_ok = 1'b0;
    endcase
  end

  // Stores commit and loads read the array at the accept edge itself.
  dmem_bram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_bram (
    .clk   (clk),
    .we    (accept && req_we && !req_err),
    .be    (be),
    .re    (accept && !req_we && !req_err),
    .addr  (req_addr[AW+1:2]),
    .wdata (wdata_lanes),
    .rdata (bram_q)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      ready_en <= 1'b0;
      meta_q   <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      ready_en <= 1'b1;
      if (accept) begin
        meta_q <= '{load: !req_we, err: req_err, funct3: req_funct3, off: off};
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = 32'h0;
    case (state)
      IDLE: begin
        req_ready = ready_en;
        if (accept) begin
          if (RD_LAT == 1) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 3'd1) state_nxt = RESP;
        else             cnt_nxt   = cnt - 3'd1;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = meta_q.err;
        if (meta_q.load && !meta_q.err) begin
          rsp_rdata = load_extend(bram_q, meta_q.funct3, meta_q.off);
        end
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: two instances (RD_LAT=1/DEPTH=128 and RD_LAT=3/DEPTH=64) driven
// through one shared request bus and checked against a byte-array reference model.
module tb_dmem_lsu;

  localparam int DEP_A = 128;
  localparam int DEP_B = 64;
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  logic        clk;
  logic        rst_n;
  logic        sel;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_ready;

  logic        a_req_ready, a_rsp_valid, a_rsp_err;
  logic [31:0] a_rsp_rdata;
  logic        b_req_ready, b_rsp_valid, b_rsp_err;
  logic [31:0] b_rsp_rdata;

  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  assign req_ready = sel ? b_req_ready : a_req_ready;
  assign rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
  assign rsp_err   = sel ? b_rsp_err   : a_rsp_err;
  assign rsp_rdata = sel ? b_rsp_rdata : a_rsp_rdata;

  dmem_lsu #(.DEPTH(DEP_A), .ADDR_W(9), .RD_LAT(LAT_A)) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid && !sel),
    .req_ready  (a_req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (a_rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (a_rsp_rdata),
    .rsp_err    (a_rsp_err)
  );

  dmem_lsu #(.DEPTH(DEP_B), .ADDR_W(9), .RD_LAT(LAT_B)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid && sel),
    .req_ready  (b_req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (b_rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (b_rsp_rdata),
    .rsp_err    (b_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference memory: one byte array per instance, indexed by byte address.
  logic [7:0] model [2][512];

  task automatic model_exec(input bit s, input bit we, input logic [2:0] f3,
                            input logic [8:0] addr, input logic [31:0] wd,
                            output logic [31:0] rd, output logic er);
    int size;
    int dep;
    int a;
    logic [31:0] v;
    dep = s ? DEP_B : DEP_A;
    a   = int'(addr);
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 0;
    endcase
    rd = 32'h0;
    er = (size == 0) || (we && f3[2]);
    if (!er) er = ((a % size) != 0) || ((a / 4) >= dep);
    if (!er) begin
      if (we) begin
        for (int i = 0; i < size; i++) model[s][a + i] = wd[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < size; i++) v[8*i +: 8] = model[s][a + i];
        if (f3 == 3'd0)      v = {{24{v[7]}}, v[7:0]};
        else if (f3 == 3'd1) v = {{16{v[15]}}, v[15:0]};
        rd = v;
      end
    end
  endtask

  // One complete transaction; hold>0 keeps rsp_ready low that many cycles while a
  // stray store is presented, which must be ignored.
  task automatic txn(input bit s, input bit we, input logic [2:0] f3, input logic [8:0] addr,
                     input logic [31:0] wd, input int hold,
                     output logic [31:0] rd, output logic er);
    logic [31:0] exp_rd;
    logic        exp_er;
    int          lat;
    int          w;
    rd = 32'h0;
    er = 1'b0;
    sel = s;
    @(negedge clk);
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    req_valid  = 1'b1;
    rsp_ready  = 1'b0;
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      check("req_ready_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    model_exec(s, we, f3, addr, wd, exp_rd, exp_er);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(s ? LAT_B : LAT_A));
    check("req_ready_in_resp", 32'(req_ready), 32'd0);
    rd = rsp_rdata;
    er = rsp_err;
    check("rdata", rd, exp_rd);
    check("err", 32'(er), 32'(exp_er));
    if (hold > 0) begin
      req_we     = 1'b1;
      req_funct3 = 3'b010;
      req_addr   = 9'h044;
      req_wdata  = 32'hA5A5_A5A5;
      req_valid  = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("hold_valid", 32'(rsp_valid), 32'd1);
        check("hold_rdata", rsp_rdata, rd);
        check("hold_ready", 32'(req_ready), 32'd0);
      end
      req_valid = 1'b0;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
    check("idle_req_ready", 32'(req_ready), 32'd1);
  endtask

  // Continuous loads with rsp_ready held high; records the accept cycles.
  task automatic stream(input bit s, input int n);
    int          acc_cyc[$];
    int          cyc;
    int          got;
    int          lat;
    logic [31:0] exp_rd;
    logic        exp_er;
    lat = s ? LAT_B : LAT_A;
    sel = s;
    model_exec(s, 1'b0, 3'b010, 9'h010, 32'h0, exp_rd, exp_er);
    @(negedge clk);
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 9'h010;
    req_valid  = 1'b1;
    rsp_ready  = 1'b1;
    cyc = 0;
    got = 0;
    do begin
      if (req_ready) begin
        acc_cyc.push_back(cyc);
        got++;
      end
      if (rsp_valid) check("stream_rdata", rsp_rdata, exp_rd);
      if (got < n) begin
        @(negedge clk);
        cyc++;
      end
    end while (got < n && cyc < 200);
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 0; i < lat + 2; i++) begin
      @(negedge clk);
      if (rsp_valid) check("stream_rdata", rsp_rdata, exp_rd);
    end
    rsp_ready = 1'b0;
    check("stream_count", 32'(got), 32'(n));
    for (int i = 1; i < acc_cyc.size(); i++) begin
      check("stream_gap", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'(lat + 1));
    end
  endtask

  task automatic start_load(input bit s, input logic [8:0] addr);
    int w;
    sel = s;
    @(negedge clk);
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = addr;
    req_valid  = 1'b1;
    rsp_ready  = 1'b0;
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("start_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] exp_rd;
    logic        exp_er;
    logic [8:0]  ra;
    bit          rwe;
    logic [2:0]  rf3;

    rst_n      = 1'b0;
    sel        = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 9'h0;
    req_wdata  = 32'h0;
    rsp_ready  = 1'b0;

    // Reset state and the one-edge delay of req_ready after release.
    repeat (2) @(negedge clk);
    check("rst_a_ready", 32'(a_req_ready), 32'd0);
    check("rst_a_valid", 32'(a_rsp_valid), 32'd0);
    check("rst_a_rdata", a_rsp_rdata, 32'h0);
    check("rst_a_err", 32'(a_rsp_err), 32'd0);
    check("rst_b_ready", 32'(b_req_ready), 32'd0);
    rst_n = 1'b1;
    #1 check("rel_a_ready_before_edge", 32'(a_req_ready), 32'd0);
    @(negedge clk);
    check("rel_a_ready", 32'(a_req_ready), 32'd1);
    check("rel_b_ready", 32'(b_req_ready), 32'd1);

    // Give every word a defined value in both instances.
    for (int i = 0; i < DEP_A; i++) txn(1'b0, 1'b1, 3'b010, 9'(i * 4), $urandom, 0, rd, er);
    for (int i = 0; i < DEP_B; i++) txn(1'b1, 1'b1, 3'b010, 9'(i * 4), $urandom, 0, rd, er);

    // Word store/load.
    txn(1'b0, 1'b1, 3'b010, 9'h010, 32'hDEAD_BEEF, 0, rd, er);
    txn(1'b0, 1'b0, 3'b010, 9'h010, 32'h0, 0, rd, er);
    check("lw_deadbeef", rd, 32'hDEAD_BEEF);
    check("lw_deadbeef_err", 32'(er), 32'd0);

    // Byte store, signed/unsigned byte loads, neighbours untouched.
    txn(1'b0, 1'b1, 3'b000, 9'h021, 32'h1234_5680, 0, rd, er);
    txn(1'b0, 1'b0, 3'b000, 9'h021, 32'h0, 0, rd, er);
    check("lb_21", rd, 32'hFFFF_FF80);
    txn(1'b0, 1'b0, 3'b100, 9'h021, 32'h0, 0, rd, er);
    check("lbu_21", rd, 32'h0000_0080);
    txn(1'b0, 1'b0, 3'b010, 9'h020, 32'h0, 0, rd, er);

    // Halfword store/load and error cases.
    txn(1'b0, 1'b1, 3'b001, 9'h032, 32'hFFFF_8001, 0, rd, er);
    txn(1'b0, 1'b0, 3'b001, 9'h032, 32'h0, 0, rd, er);
    check("lh_32", rd, 32'hFFFF_8001);
    txn(1'b0, 1'b0, 3'b101, 9'h032, 32'h0, 0, rd, er);
    check("lhu_32", rd, 32'h0000_8001);
    txn(1'b0, 1'b0, 3'b010, 9'h033, 32'h0, 0, rd, er);
    check("lw_33_err", 32'(er), 32'd1);
    check("lw_33_rdata", rd, 32'h0);
    txn(1'b0, 1'b1, 3'b001, 9'h031, 32'hFFFF_FFFF, 0, rd, er);
    check("sh_31_err", 32'(er), 32'd1);
    txn(1'b0, 1'b1, 3'b011, 9'h030, 32'hFFFF_FFFF, 0, rd, er);
    check("f3_011_err", 32'(er), 32'd1);
    txn(1'b0, 1'b1, 3'b100, 9'h030, 32'hFFFF_FFFF, 0, rd, er);
    check("sbu_err", 32'(er), 32'd1);
    txn(1'b0, 1'b0, 3'b010, 9'h030, 32'h0, 0, rd, er);

    // Response back-pressure with a stray store presented meanwhile.
    txn(1'b0, 1'b0, 3'b010, 9'h010, 32'h0, 5, rd, er);
    check("hold_data", rd, 32'hDEAD_BEEF);
    txn(1'b0, 1'b0, 3'b010, 9'h044, 32'h0, 0, rd, er);

    // Long-latency, shallow instance: range limit and latency.
    txn(1'b1, 1'b0, 3'b010, 9'h100, 32'h0, 0, rd, er);
    check("b_oor_err", 32'(er), 32'd1);
    check("b_oor_rdata", rd, 32'h0);
    txn(1'b1, 1'b1, 3'b010, 9'h1FC, 32'h1111_2222, 0, rd, er);
    check("b_oor_store_err", 32'(er), 32'd1);
    txn(1'b1, 1'b1, 3'b010, 9'h0FC, 32'hCAFE_F00D, 0, rd, er);
    txn(1'b1, 1'b0, 3'b010, 9'h0FC, 32'h0, 0, rd, er);
    check("b_top_word", rd, 32'hCAFE_F00D);

    // Peak throughput.
    stream(1'b0, 5);
    stream(1'b1, 5);

    // Reset while a response is presented.
    start_load(1'b0, 9'h010);
    @(negedge clk);
    check("pre_rst_resp_valid", 32'(a_rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1 check("rst_resp_valid", 32'(a_rsp_valid), 32'd0);
    check("rst_resp_rdata", a_rsp_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_a_valid", 32'(a_rsp_valid), 32'd0);
    check("post_rst_a_ready", 32'(a_req_ready), 32'd1);

    // Reset while waiting on the long-latency read.
    txn(1'b1, 1'b1, 3'b010, 9'h020, 32'h0BAD_F00D, 0, rd, er);
    start_load(1'b1, 9'h020);
    @(negedge clk);
    check("wait_no_valid", 32'(b_rsp_valid), 32'd0);
    rst_n = 1'b0;
    #1 check("rst_wait_valid", 32'(b_rsp_valid), 32'd0);
    check("rst_wait_ready", 32'(b_req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no_rsp_after_rst", 32'(b_rsp_valid), 32'd0);
    end
    txn(1'b1, 1'b0, 3'b010, 9'h020, 32'h0, 0, rd, er);
    check("store_survives_rst", rd, 32'h0BAD_F00D);
    txn(1'b0, 1'b0, 3'b010, 9'h010, 32'h0, 0, rd, er);

    // Random mix against the model.
    for (int n = 0; n < 500; n++) begin
      ra  = 9'($urandom_range(0, 511));
      if ($urandom_range(0, 1) == 1) ra[1:0] = 2'b00;
      rwe = ($urandom_range(0, 2) == 0);
      rf3 = 3'($urandom_range(0, 7));
      txn(n[0], rwe, rf3, ra, $urandom, 0, rd, er);
    end

    model_exec(1'b0, 1'b0, 3'b010, 9'h010, 32'h0, exp_rd, exp_er);
    txn(1'b0, 1'b0, 3'b010, 9'h010, 32'h0, 0, rd, er);
    check("final_err", 32'(er), 32'(exp_er));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
